// File: rtl/fetch_stage_pkg.sv
// Shared Y86 constants, types and byte helpers for the fetch stage.
package fetch_stage_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;

  // Instruction codes (upper nibble of the first instruction byte)
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOPC   = 4'h1;
  localparam logic [3:0] IRRMOVL = 4'h2;
  localparam logic [3:0] IIRMOVL = 4'h3;
  localparam logic [3:0] IRMMOVL = 4'h4;
  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHL  = 4'hA;
  localparam logic [3:0] IPOPL   = 4'hB;

  localparam byte_t INOP  = 8'h01;
  localparam byte_t RNONE = 8'h0F;
  localparam byte_t RESP  = 8'h04;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {REQ, DRAIN, READY, HALTED} fetch_state_e;
  typedef enum logic [1:0] {VALC_NONE, VALC_AT1, VALC_AT2} valc_sel_e;
  typedef enum logic [1:0] {DSTE_NONE, DSTE_RB, DSTE_RESP} dste_sel_e;

  typedef struct packed {
    byte_t icode;
    byte_t ifun;
    byte_t ra;
    byte_t rb;
    byte_t dste;
    byte_t dstm;
    word_t valc;
    word_t valp;
    word_t pc;
    logic  valid;
  } fetch_out_t;

  // Bubble presented to decode whenever no complete instruction is held
  localparam fetch_out_t NOP_OUT = '{icode: INOP, ifun: 8'h00, ra: RNONE, rb: RNONE,
                                     dste: RNONE, dstm: RNONE, valc: 32'h0000_0000,
                                     valp: 32'h0000_0000, pc: 32'h0000_0000, valid: 1'b0};

  function automatic word_t word_align(input word_t a);
    word_align = {a[31:2], 2'b00};
  endfunction

  // Little-endian byte lane select: lane 0 is the lowest address
  function automatic byte_t word_byte(input word_t w, input logic [1:0] idx);
    case (idx)
      2'd0:    word_byte = w[7:0];
      2'd1:    word_byte = w[15:8];
      2'd2:    word_byte = w[23:16];
      default: word_byte = w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/fetch_stage_instr_len_decode.sv
// Per-icode static properties: length, register byte, constant position, destinations.
module instr_len_decode
  import fetch_stage_pkg::*;
(
  input  logic [3:0] icode,
  output logic [2:0] len,
  output logic       need_regids,
  output valc_sel_e  valc_sel,
  output dste_sel_e  dste_sel,
  output logic       dstm_ra
);

  // Table lookup; unknown icodes are treated as single-byte instructions
  always_comb begin
    len         = 3'd1;
    need_regids = 1'b0;
    valc_sel    = VALC_NONE;
    dste_sel    = DSTE_NONE;
    dstm_ra     = 1'b0;
    case (icode)
      IHALT, INOPC: begin
        len = 3'd1;
      end
      IRET: begin
        len      = 3'd1;
        dste_sel = DSTE_RESP;
      end
      IRRMOVL, IOPL: begin
        len         = 3'd2;
        need_regids = 1'b1;
        dste_sel    = DSTE_RB;
      end
      IPUSHL: begin
        len         = 3'd2;
        need_regids = 1'b1;
        dste_sel    = DSTE_RESP;
      end
      IPOPL: begin
        len         = 3'd2;
        need_regids = 1'b1;
        dste_sel    = DSTE_RESP;
        dstm_ra     = 1'b1;
      end
      IJXX: begin
        len      = 3'd5;
        valc_sel = VALC_AT1;
      end
      ICALL: begin
        len      = 3'd5;
        valc_sel = VALC_AT1;
        dste_sel = DSTE_RESP;
      end
      IIRMOVL: begin
        len         = 3'd6;
        need_regids = 1'b1;
        valc_sel    = VALC_AT2;
        dste_sel    = DSTE_RB;
      end
      IRMMOVL: begin
        len         = 3'd6;
        need_regids = 1'b1;
        valc_sel    = VALC_AT2;
      end
      IMRMOVL: begin
        len         = 3'd6;
        need_regids = 1'b1;
        valc_sel    = VALC_AT2;
        dstm_ra     = 1'b1;
      end
      default: begin
        len = 3'd1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86 fetch stage: word-wide instruction fetch, unaligned byte assembly and field decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  F_stall_i,
  input  logic  redir_valid_i,
  input  word_t redir_pc_i,
  output logic  imem_req_o,
  output word_t imem_addr_o,
  input  logic  imem_ack_i,
  input  word_t imem_rdata_i,
  output byte_t f_icode_o,
  output byte_t f_ifun_o,
  output byte_t f_rA_o,
  output byte_t f_rB_o,
  output byte_t f_dstE_o,
  output byte_t f_dstM_o,
  output word_t f_valC_o,
  output word_t f_valP_o,
  output word_t f_pc_o,
  output logic  f_valid_o
);

  fetch_state_e state_r;
  word_t        pc_r;
  word_t        waddr_r;
  word_t        pred_r;
  byte_t        ibuf_r [0:5];
  logic [2:0]   cnt_r;
  logic         req_r;
  fetch_out_t   out_r;

  logic [1:0]   off_s;
  logic [2:0]   nnew_s;
  logic [2:0]   lane_s;
  logic [3:0]   sum_s;
  logic [2:0]   ncnt_s;
  byte_t        nbuf_s [0:5];

  logic [2:0]   len_s;
  logic         need_regids_s;
  valc_sel_e    valc_sel_s;
  dste_sel_e    dste_sel_s;
  logic         dstm_ra_s;
  word_t        valc_s;
  word_t        pred_s;
  logic         done_s;
  fetch_out_t   dec_s;

  instr_len_decode u_len_decode (
    .icode       (nbuf_s[0][7:4]),
    .len         (len_s),
    .need_regids (need_regids_s),
    .valc_sel    (valc_sel_s),
    .dste_sel    (dste_sel_s),
    .dstm_ra     (dstm_ra_s)
  );

  // Merge the arriving word into the byte buffer (first word starts at pc[1:0])
  always_comb begin
    off_s  = (cnt_r == 3'd0) ? pc_r[1:0] : 2'd0;
    nnew_s = 3'd4 - {1'b0, off_s};
    lane_s = 3'd0;
    for (int j = 0; j < 6; j++) begin
      lane_s    = 3'(j) - cnt_r;
      nbuf_s[j] = ((3'(j) >= cnt_r) && (lane_s < nnew_s))
                  ? word_byte(imem_rdata_i, off_s + lane_s[1:0]) : ibuf_r[j];
    end
    sum_s  = {1'b0, cnt_r} + {1'b0, nnew_s};
    ncnt_s = (sum_s > 4'd6) ? 3'd6 : sum_s[2:0];
  end

  // Decode the merged buffer into the fields loaded when the instruction completes
  always_comb begin
    case (valc_sel_s)
      VALC_AT1: valc_s = {nbuf_s[4], nbuf_s[3], nbuf_s[2], nbuf_s[1]};
      VALC_AT2: valc_s = {nbuf_s[5], nbuf_s[4], nbuf_s[3], nbuf_s[2]};
      default:  valc_s = 32'h0000_0000;
    endcase
    dec_s.icode = {4'h0, nbuf_s[0][7:4]};
    dec_s.ifun  = {4'h0, nbuf_s[0][3:0]};
    dec_s.ra    = need_regids_s ? {4'h0, nbuf_s[1][7:4]} : RNONE;
    dec_s.rb    = need_regids_s ? {4'h0, nbuf_s[1][3:0]} : RNONE;
    case (dste_sel_s)
      DSTE_RB:   dec_s.dste = dec_s.rb;
      DSTE_RESP: dec_s.dste = RESP;
      default:   dec_s.dste = RNONE;
    endcase
    dec_s.dstm  = dstm_ra_s ? dec_s.ra : RNONE;
    dec_s.valc  = valc_s;
    dec_s.valp  = pc_r + {29'd0, len_s};
    dec_s.pc    = pc_r;
    dec_s.valid = 1'b1;
    pred_s = ((nbuf_s[0][7:4] == IJXX) || (nbuf_s[0][7:4] == ICALL)) ? valc_s : dec_s.valp;
    done_s = (ncnt_s >= len_s);
  end

  // Fetch FSM: request words, assemble, present, advance; redirects override everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= REQ;
      pc_r    <= RESET_PC;
      waddr_r <= word_align(RESET_PC);
      pred_r  <= 32'h0000_0000;
      cnt_r   <= 3'd0;
      req_r   <= DISABLE;
      out_r   <= NOP_OUT;
      for (int i = 0; i < 6; i++) ibuf_r[i] <= 8'h00;
    end else if (redir_valid_i) begin
      pc_r  <= redir_pc_i;
      cnt_r <= 3'd0;
      out_r <= NOP_OUT;
      case (state_r)
        REQ: begin
          if (req_r && !imem_ack_i) begin
            state_r <= DRAIN;
          end else begin
            state_r <= REQ;
            waddr_r <= word_align(redir_pc_i);
            req_r   <= ENABLE;
          end
        end
        DRAIN: begin
          if (imem_ack_i) begin
            state_r <= REQ;
            waddr_r <= word_align(redir_pc_i);
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r <= REQ;
          waddr_r <= word_align(redir_pc_i);
          req_r   <= ENABLE;
        end
      endcase
    end else begin
      case (state_r)
        REQ: begin
          if (!req_r) begin
            req_r <= ENABLE;
          end else if (imem_ack_i) begin
            for (int i = 0; i < 6; i++) ibuf_r[i] <= nbuf_s[i];
            cnt_r <= ncnt_s;
            if (done_s) begin
              state_r <= READY;
              req_r   <= DISABLE;
              out_r   <= dec_s;
              pred_r  <= pred_s;
            end else begin
              waddr_r <= waddr_r + 32'd4;
            end
          end else begin
            state_r <= REQ;
          end
        end
        DRAIN: begin
          if (imem_ack_i) begin
            state_r <= REQ;
            waddr_r <= word_align(pc_r);
          end else begin
            state_r <= DRAIN;
          end
        end
        READY: begin
          if (!F_stall_i) begin
            out_r <= NOP_OUT;
            if (out_r.icode == {4'h0, IHALT}) begin
              state_r <= HALTED;
            end else begin
              state_r <= REQ;
              pc_r    <= pred_r;
              waddr_r <= word_align(pred_r);
              cnt_r   <= 3'd0;
              req_r   <= ENABLE;
            end
          end else begin
            state_r <= READY;
          end
        end
        HALTED: begin
          state_r <= HALTED;
        end
        default: begin
          state_r <= REQ;
        end
      endcase
    end
  end

  assign imem_req_o  = req_r;
  assign imem_addr_o = waddr_r;
  assign f_icode_o   = out_r.icode;
  assign f_ifun_o    = out_r.ifun;
  assign f_rA_o      = out_r.ra;
  assign f_rB_o      = out_r.rb;
  assign f_dstE_o    = out_r.dste;
  assign f_dstM_o    = out_r.dstm;
  assign f_valC_o    = out_r.valc;
  assign f_valP_o    = out_r.valp;
  assign f_pc_o      = out_r.pc;
  assign f_valid_o   = out_r.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: byte-addressed memory responder, scoreboard of fetched instructions.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall_i;
  logic        redir_valid_i;
  logic [31:0] redir_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [7:0]  f_icode_o, f_ifun_o, f_rA_o, f_rB_o, f_dstE_o, f_dstM_o;
  logic [31:0] f_valC_o, f_valP_o, f_pc_o;
  logic        f_valid_o;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .F_stall_i(F_stall_i),
    .redir_valid_i(redir_valid_i), .redir_pc_i(redir_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .f_icode_o(f_icode_o), .f_ifun_o(f_ifun_o), .f_rA_o(f_rA_o), .f_rB_o(f_rB_o),
    .f_dstE_o(f_dstE_o), .f_dstM_o(f_dstM_o), .f_valC_o(f_valC_o),
    .f_valP_o(f_valP_o), .f_pc_o(f_pc_o), .f_valid_o(f_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  icode, ra, rb, dste, dstm;
    logic [31:0] valc, valp, pc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] req_log[$];
  logic [31:0] exp_reqs[$];
  logic [7:0]  mem [0:255];
  int          n_assert = 0;
  int          n_fail = 0;
  int          ack_wait = 0;
  int          wait_cnt = 0;
  logic        last_valid = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [7:0] icode, input logic [7:0] ra,
                          input logic [7:0] rb, input logic [7:0] dste, input logic [7:0] dstm,
                          input logic [31:0] valc, input logic [31:0] valp);
    exp_t e;
    e.pc = pc; e.icode = icode; e.ra = ra; e.rb = rb;
    e.dste = dste; e.dstm = dstm; e.valc = valc; e.valp = valp;
    sb.push_back(e);
  endtask

  // One cycle: observe at negedge, check handshake and scoreboard, then drive memory response
  task automatic tick();
    exp_t e;
    logic [7:0] a;
    @(negedge clk);
    if (pend) begin
      chk("req_hold", {31'h0, imem_req_o}, 32'h1);
      chk("addr_hold", imem_addr_o, pend_addr);
    end
    if (f_valid_o && !last_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_instr", sb.size(), 32'h1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("pc@%0h", e.pc), f_pc_o, e.pc);
        chk($sformatf("icode@%0h", e.pc), {24'h0, f_icode_o}, {24'h0, e.icode});
        chk($sformatf("ifun@%0h", e.pc), {24'h0, f_ifun_o}, 32'h0);
        chk($sformatf("rA@%0h", e.pc), {24'h0, f_rA_o}, {24'h0, e.ra});
        chk($sformatf("rB@%0h", e.pc), {24'h0, f_rB_o}, {24'h0, e.rb});
        chk($sformatf("dstE@%0h", e.pc), {24'h0, f_dstE_o}, {24'h0, e.dste});
        chk($sformatf("dstM@%0h", e.pc), {24'h0, f_dstM_o}, {24'h0, e.dstm});
        chk($sformatf("valC@%0h", e.pc), f_valC_o, e.valc);
        chk($sformatf("valP@%0h", e.pc), f_valP_o, e.valp);
      end
    end
    last_valid = f_valid_o;
    if (imem_req_o && (wait_cnt >= ack_wait)) begin
      a = imem_addr_o[7:0];
      imem_ack_i   = 1'b1;
      imem_rdata_i = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
      req_log.push_back(imem_addr_o);
      wait_cnt = 0;
    end else begin
      imem_ack_i   = 1'b0;
      imem_rdata_i = 32'hDEAD_BEEF;
      if (imem_req_o) wait_cnt++;
    end
    pend      = imem_req_o && !imem_ack_i;
    pend_addr = imem_addr_o;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redir_valid_i = 1'b1;
    redir_pc_i    = pc;
    tick();
    redir_valid_i = 1'b0;
    redir_pc_i    = 32'h0;
  endtask

  task automatic run_until_idle(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!((sb.size() == 0) && !imem_req_o && !f_valid_o) && (n < 300));
    chk({tag, "_idle"}, {31'h0, (sb.size() == 0) && !imem_req_o && !f_valid_o}, 32'h1);
  endtask

  task automatic check_reqs(input string tag);
    chk({tag, "_nreq"}, req_log.size(), exp_reqs.size());
    for (int i = 0; i < exp_reqs.size() && i < req_log.size(); i++)
      chk($sformatf("%s_req%0d", tag, i), req_log[i], exp_reqs[i]);
    req_log.delete();
    exp_reqs.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10;                                            // nop ; halt at 0x01
    mem[8'h02] = 8'h30; mem[8'h03] = 8'hF3; mem[8'h04] = 8'h78;    // irmovl at 0x02
    mem[8'h05] = 8'h56; mem[8'h06] = 8'h34; mem[8'h07] = 8'h12;
    mem[8'h10] = 8'h70; mem[8'h11] = 8'h40;                        // jmp 0x40
    mem[8'h23] = 8'h30; mem[8'h24] = 8'hF3; mem[8'h25] = 8'h78;    // irmovl at 0x23
    mem[8'h26] = 8'h56; mem[8'h27] = 8'h34; mem[8'h28] = 8'h12;
    mem[8'h40] = 8'h60; mem[8'h41] = 8'h12;                        // addl %ecx,%edx
    mem[8'h42] = 8'hB0; mem[8'h43] = 8'h3F;                        // popl %ebx
    mem[8'h44] = 8'h80; mem[8'h45] = 8'h60;                        // call 0x60
    mem[8'h60] = 8'h50; mem[8'h61] = 8'h21; mem[8'h62] = 8'h04;    // mrmovl 4(%ecx),%edx
    mem[8'h80] = 8'h10;                                            // nop ; halt at 0x81

    rst = 1'b0; F_stall_i = 1'b0; redir_valid_i = 1'b0; redir_pc_i = 32'h0;
    imem_ack_i = 1'b0; imem_rdata_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'h0, imem_req_o}, 32'h0);
    chk("rst_valid", {31'h0, f_valid_o}, 32'h0);
    chk("rst_icode", {24'h0, f_icode_o}, 32'h1);
    chk("rst_rA", {24'h0, f_rA_o}, 32'hF);
    chk("rst_dstE", {24'h0, f_dstE_o}, 32'hF);
    chk("rst_valC", f_valC_o, 32'h0);
    chk("rst_valP", f_valP_o, 32'h0);
    rst = 1'b1;

    // nop then halt from reset, with a two-cycle stall on the halt
    push_exp(32'h00, 8'h01, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 32'h0, 32'h01);
    push_exp(32'h01, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 32'h0, 32'h02);
    exp_reqs = '{32'h00, 32'h00};
    n = 0;
    do begin tick(); n++; end while (!f_valid_o && n < 20);
    chk("nop_latency", n, 2);
    n = 0;
    do begin tick(); n++; end while (!(f_valid_o && f_icode_o == 8'h00) && n < 20);
    chk("halt_seen", {31'h0, f_valid_o}, 32'h1);
    F_stall_i = 1'b1;
    repeat (2) begin
      tick();
      chk("stall_valid", {31'h0, f_valid_o}, 32'h1);
      chk("stall_icode", {24'h0, f_icode_o}, 32'h0);
      chk("stall_pc", f_pc_o, 32'h1);
      chk("stall_req", {31'h0, imem_req_o}, 32'h0);
    end
    F_stall_i = 1'b0;
    tick();
    chk("halted_valid", {31'h0, f_valid_o}, 32'h0);
    chk("halted_icode", {24'h0, f_icode_o}, 32'h1);
    repeat (4) begin
      tick();
      chk("halted_req", {31'h0, imem_req_o}, 32'h0);
    end
    check_reqs("s1");

    // irmovl at 0x02 spanning two words
    push_exp(32'h02, 8'h03, 8'h0F, 8'h03, 8'h03, 8'h0F, 32'h1234_5678, 32'h08);
    push_exp(32'h08, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 32'h0, 32'h09);
    exp_reqs = '{32'h00, 32'h04, 32'h08};
    redirect(32'h02);
    run_until_idle("s2");
    check_reqs("s2");

    // irmovl at 0x23 spanning three words
    push_exp(32'h23, 8'h03, 8'h0F, 8'h03, 8'h03, 8'h0F, 32'h1234_5678, 32'h29);
    push_exp(32'h29, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 32'h0, 32'h2A);
    exp_reqs = '{32'h20, 32'h24, 32'h28, 32'h28};
    redirect(32'h23);
    run_until_idle("s3");
    check_reqs("s3");

    // jmp, addl, popl, call, mrmovl, halt following predicted PCs
    push_exp(32'h10, 8'h07, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 32'h40, 32'h15);
    push_exp(32'h40, 8'h06, 8'h01, 8'h02, 8'h02, 8'h0F, 32'h0, 32'h42);
    push_exp(32'h42, 8'h0B, 8'h03, 8'h0F, 8'h04, 8'h03, 32'h0, 32'h44);
    push_exp(32'h44, 8'h08, 8'h0F, 8'h0F, 8'h04, 8'h0F, 32'h60, 32'h49);
    push_exp(32'h60, 8'h05, 8'h02, 8'h01, 8'h0F, 8'h02, 32'h4, 32'h66);
    push_exp(32'h66, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 32'h0, 32'h67);
    exp_reqs = '{32'h10, 32'h14, 32'h40, 32'h40, 32'h44, 32'h48, 32'h60, 32'h64, 32'h64};
    redirect(32'h10);
    run_until_idle("s4");
    check_reqs("s4");

    // slow memory: redirect while a request is outstanding, stale data dropped
    ack_wait = 3;
    push_exp(32'h80, 8'h01, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 32'h0, 32'h81);
    push_exp(32'h81, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 32'h0, 32'h82);
    exp_reqs = '{32'h10, 32'h80, 32'h80};
    redirect(32'h10);
    redirect(32'h80);
    chk("drain_req", {31'h0, imem_req_o}, 32'h1);
    chk("drain_addr", imem_addr_o, 32'h10);
    chk("drain_valid", {31'h0, f_valid_o}, 32'h0);
    run_until_idle("s5");
    check_reqs("s5");

    // redirect arriving together with ack: that word is dropped
    ack_wait = 0;
    push_exp(32'h80, 8'h01, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 32'h0, 32'h81);
    push_exp(32'h81, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 32'h0, 32'h82);
    exp_reqs = '{32'h40, 32'h80, 32'h80};
    redirect(32'h40);
    redirect(32'h80);
    run_until_idle("s6");
    check_reqs("s6");

    chk("sb_left", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
